// File: rtl/serial_add_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// serial_add_pkg
// Shared definitions for the bit-serial adder controller.
//   state_t        : controller FSM encoding (IDLE, RUN, DONE)
//   WIDTH_DEFAULT  : default operand/result width
// -----------------------------------------------------------------------------
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl_if
// Request/result bundle of the bit-serial adder.
//
// Handshake: the requester raises start with a/b (and sub, when
// SERIAL_ADD_SUB_EN is defined) stable. The adder accepts on the first rising
// edge where it is idle and start=1; operands are captured on that edge. busy
// is high for the WIDTH cycles of the operation, then done pulses for exactly
// one cycle with sum/cout valid. start seen while busy or done is dropped,
// not queued. done and busy are never high together.
//
// Signals:
//   start  (master->slave) operation request
//   a, b   (master->slave) operands, WIDTH bits
//   sub    (master->slave) subtract select, only with SERIAL_ADD_SUB_EN
//   sum    (slave->master) result register, WIDTH bits
//   cout   (slave->master) final carry out (no-borrow flag when subtracting)
//   busy   (slave->master) operation in progress
//   done   (slave->master) one-cycle completion pulse
//   state  (slave->master) FSM state, for observation only
// -----------------------------------------------------------------------------
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub;
`endif
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             busy;
    logic             done;
    state_t           state;

    modport master (
`ifdef SERIAL_ADD_SUB_EN
        output sub,
`endif
        output start, a, b,
        input  sum, cout, busy, done, state
    );

    modport slave (
`ifdef SERIAL_ADD_SUB_EN
        input  sub,
`endif
        input  start, a, b,
        output sum, cout, busy, done, state
    );

endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// -----------------------------------------------------------------------------
// serial_fa_cell
// Combinational one-bit full adder built from two half-adder stages.
//   x, y  : operand bits
//   ci    : carry in
//   s     : sum bit
//   co    : carry out
// -----------------------------------------------------------------------------
module serial_fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);
    logic s1;
    logic c1;
    logic c2;

    assign s1 = x ^ y;
    assign c1 = x & y;
    assign s  = s1 ^ ci;
    assign c2 = s1 & ci;
    assign co = c1 | c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// serial_add_ctrl
// Bit-serial WIDTH-bit adder: one full-adder cell is reused across all bit
// positions, LSB first, one bit per clock. {cout,sum} = a + b (mod 2^(WIDTH+1)).
// Optional macro SERIAL_ADD_SUB_EN adds a sub input: sub=1 computes a - b in
// two's complement, with cout=1 meaning no borrow.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    serial_add_ctrl_if.slave (start, a, b, [sub], sum, cout, busy,
//          done, state)
// The WIDTH parameter must match the interface instance's WIDTH.
// -----------------------------------------------------------------------------
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    serial_add_ctrl_if.slave bus
);
    localparam int              CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic [CNT_W-1:0] cnt_q;

    logic             cell_s;
    logic             cell_co;
    logic [WIDTH-1:0] b_load;
    logic             carry_init;
    logic             accept;

`ifdef SERIAL_ADD_SUB_EN
    // Subtraction is a + ~b + 1: invert b on load and seed the carry with 1.
    assign b_load     = bus.sub ? ~bus.b : bus.b;
    assign carry_init = bus.sub;
`else
    assign b_load     = bus.b;
    assign carry_init = 1'b0;
`endif

    assign accept = (state_q == IDLE) && bus.start;

    serial_fa_cell u_cell (
        .x  (a_sr[0]),
        .y  (b_sr[0]),
        .ci (carry_q),
        .s  (cell_s),
        .co (cell_co)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath: operand shift registers, carry flop, bit counter, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_sr    <= bus.a;
            b_sr    <= b_load;
            carry_q <= carry_init;
            cnt_q   <= '0;
        end else if (state_q == RUN) begin
            // Result bits enter at the MSB; after WIDTH shifts bit 0 sits at LSB.
            sum_q   <= {cell_s, sum_q[WIDTH-1:1]};
            a_sr    <= a_sr >> 1;
            b_sr    <= b_sr >> 1;
            carry_q <= cell_co;
            cnt_q   <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
                cout_q <= cell_co;
            end
        end
    end

    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
    assign bus.busy  = (state_q == RUN);
    assign bus.done  = (state_q == DONE);
    assign bus.state = state_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_add_ctrl
// Directed and random stimulus for serial_add_ctrl with a result scoreboard.
// Build with SERIAL_ADD_SUB_EN defined to also exercise the subtract path.
// -----------------------------------------------------------------------------
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W = WIDTH_DEFAULT;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(W)) bus ();

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    // ---------------- scoreboard state ----------------
    int           n_checks = 0;
    int           n_fail   = 0;
    logic [W:0]   exp_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic, independent of the serial datapath.
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic s);
        logic [W-1:0] diff;
        if (s) begin
            diff  = x - y;
            model = {(x >= y), diff};
        end else begin
            model = {1'b0, x} + {1'b0, y};
        end
    endfunction

    // Monitor: every done pulse pops one expected result.
    always @(posedge clk) begin
        logic [W:0] e;
        #1;
        if (rst_n) begin
            check("done_busy_excl", {63'd0, bus.done & bus.busy}, 64'd0);
            if (bus.done) begin
                check("queue_nonempty_on_done", {63'd0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("result", {bus.cout, bus.sum}, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_sub(input logic s);
`ifdef SERIAL_ADD_SUB_EN
        bus.sub = s;
`else
        if (s) $display("note: sub requested without SERIAL_ADD_SUB_EN");
`endif
    endtask

    // One operation from idle: checks latency, busy length, done width, hold.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int   k;
        int   busy_n;
        logic seen;
        bus.a = x;
        bus.b = y;
        drive_sub(s);
        bus.start = 1'b1;
        exp_q.push_back(model(x, y, s));
        tick();                      // accepting edge T0
        bus.start = 1'b0;
        busy_n = bus.busy ? 1 : 0;
        seen   = 1'b0;
        for (k = 1; k <= 4 * W; k++) begin
            tick();
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_n++;
        end
        check("done_seen", {63'd0, seen}, 64'd1);
        check("latency", 64'(k), 64'(W));
        check("busy_cycles", 64'(busy_n), 64'(W));
        tick();
        check("done_one_cycle", {63'd0, bus.done}, 64'd0);
        check("idle_after_done", {62'd0, bus.state}, {62'd0, IDLE});
        check("result_held", {bus.cout, bus.sum}, model(x, y, s));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int k;
        int d[3];
        int nd;
        int cnt;
        logic seen;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        drive_sub(1'b0);
        #1;
        check("rst_sum",   bus.sum,  0);
        check("rst_cout",  {63'd0, bus.cout}, 64'd0);
        check("rst_busy",  {63'd0, bus.busy}, 64'd0);
        check("rst_done",  {63'd0, bus.done}, 64'd0);
        check("rst_state", {62'd0, bus.state}, {62'd0, IDLE});
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_busy", {63'd0, bus.busy}, 64'd0);

        // Basic add and wrap-around cases
        run_op(8'h35, 8'h4A, 1'b0);
        check("basic_sum",  bus.sum,  64'h7F);
        check("basic_cout", {63'd0, bus.cout}, 64'd0);
        run_op(8'hFF, 8'h01, 1'b0);
        check("wrap1", {bus.cout, bus.sum}, 64'h100);
        run_op(8'hFF, 8'hFF, 1'b0);
        check("wrap2", {bus.cout, bus.sum}, 64'h1FE);
        run_op(8'h00, 8'h00, 1'b0);

        // start held and operands changed mid-operation
        bus.a = 8'h12;
        bus.b = 8'h34;
        bus.start = 1'b1;
        exp_q.push_back(model(8'h12, 8'h34, 1'b0));
        tick();                      // T0
        tick();
        tick();
        tick();                      // T3
        bus.a = 8'hAA;
        bus.b = 8'hCC;
        seen = 1'b0;
        for (k = 0; k < 4 * W; k++) begin
            tick();
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
        end
        check("busy_start_done_seen", {63'd0, seen}, 64'd1);
        check("busy_start_result", {bus.cout, bus.sum}, 64'h046);
        bus.start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done || bus.busy) cnt++;
        end
        check("no_second_op", 64'(cnt), 64'd0);

        // Reset in the middle of RUN
        bus.a = 8'h5A;
        bus.b = 8'h3C;
        bus.start = 1'b1;
        tick();                      // T0
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        check("mid_busy_before_rst", {63'd0, bus.busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_sum",   bus.sum, 0);
        check("mid_rst_cout",  {63'd0, bus.cout}, 64'd0);
        check("mid_rst_busy",  {63'd0, bus.busy}, 64'd0);
        check("mid_rst_done",  {63'd0, bus.done}, 64'd0);
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (bus.done) cnt++;
        end
        check("no_done_after_rst", 64'(cnt), 64'd0);
        run_op(8'h5A, 8'h3C, 1'b0);

        // Back-to-back with start held high
        bus.a = 8'h01;
        bus.b = 8'h02;
        bus.start = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        nd = 0;
        for (k = 0; k < 60 && nd < 3; k++) begin
            tick();
            if (bus.done) begin
                d[nd] = k;
                nd++;
                check("b2b_sum", bus.sum, 64'h03);
            end
        end
        bus.start = 1'b0;
        check("b2b_pulses", 64'(nd), 64'd3);
        if (nd == 3) begin
            check("b2b_spacing1", 64'(d[1] - d[0]), 64'(W + 2));
            check("b2b_spacing2", 64'(d[2] - d[1]), 64'(W + 2));
        end
        tick();
        tick();

        // Random additions
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), 1'b0);
        end

`ifdef SERIAL_ADD_SUB_EN
        run_op(8'h10, 8'h01, 1'b1);
        check("sub1", {bus.cout, bus.sum}, 64'h10F);
        run_op(8'h00, 8'h01, 1'b1);
        check("sub2", {bus.cout, bus.sum}, 64'h0FF);
        run_op(8'h35, 8'h4A, 1'b0);
        check("sub_off_add", {bus.cout, bus.sum}, 64'h07F);
        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom_range(0, (1 << W) - 1)), W'($urandom_range(0, (1 << W) - 1)), 1'b1);
        end
`endif

        tick();
        tick();
        tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
